// File: rtl/wb_stage.sv
// Writeback stage: captures ALU/load results, waits for load data, formats it,
// drives the GPR write port and forwards the write value to decode operands.
module wb_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rd_addr,
  input  logic            in_rd_en,
  input  logic            in_is_load,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [1:0]      in_load_size,
  input  logic            in_load_unsigned,
  input  logic [1:0]      in_addr_low,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            gpr_we_,
  output logic [4:0]      gpr_wr_addr,
  output logic [XLEN-1:0] gpr_wr_data,
  input  logic [4:0]      rd_addr_0,
  input  logic [4:0]      rd_addr_1,
  input  logic [XLEN-1:0] gpr_rd_data_0,
  input  logic [XLEN-1:0] gpr_rd_data_1,
  output logic [XLEN-1:0] op_data_0,
  output logic [XLEN-1:0] op_data_1,
  output logic            load_busy,
  output logic [4:0]      load_busy_rd
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_MEM = 2'd1;
  localparam logic [1:0] WRITE    = 2'd2;

  logic [1:0]      state;
  logic [4:0]      rd_q;
  logic            rd_en_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [1:0]      off_q;
  logic [XLEN-1:0] data_q;

  logic            accept;
  logic            write_act;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_data;

  assign in_ready  = (state != WAIT_MEM);
  assign accept    = in_valid && in_ready;
  assign write_act = (state == WRITE) && rd_en_q && (rd_q != 5'd0);

  assign gpr_we_     = !write_act;
  assign gpr_wr_addr = rd_q;
  assign gpr_wr_data = data_q;

  // write_act already excludes x0, so the address compare alone is safe
  assign op_data_0 = (write_act && (rd_addr_0 == rd_q)) ? data_q : gpr_rd_data_0;
  assign op_data_1 = (write_act && (rd_addr_1 == rd_q)) ? data_q : gpr_rd_data_1;

  assign load_busy    = (state == WAIT_MEM) && rd_en_q && (rd_q != 5'd0);
  assign load_busy_rd = load_busy ? rd_q : 5'd0;

  always_comb begin
    byte_sel  = mem_rdata[7:0];
    half_sel  = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = mem_rdata;
    case (off_q)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    case (size_q)
      2'b00:   load_data = uns_q ? {{(XLEN-8){1'b0}}, byte_sel}
                                 : {{(XLEN-8){byte_sel[7]}}, byte_sel};
      2'b01:   load_data = uns_q ? {{(XLEN-16){1'b0}}, half_sel}
                                 : {{(XLEN-16){half_sel[15]}}, half_sel};
      default: load_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rd_q    <= '0;
      rd_en_q <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      off_q   <= '0;
      data_q  <= '0;
    end else begin
      case (state)
        WAIT_MEM: begin
          if (mem_rvalid) begin
            data_q <= load_data;
            state  <= WRITE;
          end
        end
        default: begin
          if (accept) begin
            rd_q    <= in_rd_addr;
            rd_en_q <= in_rd_en;
            size_q  <= in_load_size;
            uns_q   <= in_load_unsigned;
            off_q   <= in_addr_low;
            if (in_is_load) begin
              state <= WAIT_MEM;
            end else begin
              data_q <= in_alu_result;
              state  <= WRITE;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter: XLEN, 32, datapath width; only 32 is supported.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  upstream result valid.
REQ-005 SHALL have port: in_ready  output  1  stage can accept an input this cycle.
REQ-006 SHALL have port: in_rd_addr  input  5  destination register.
REQ-007 SHALL have port: in_rd_en  input  1  instruction writes a register.
REQ-008 SHALL have port: in_is_load  input  1  result comes from memory.
REQ-009 SHALL have port: in_alu_result  input  XLEN  non-load result.
REQ-010 SHALL have port: in_load_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-011 SHALL have port: in_load_unsigned  input  1  zero-extend when set, else sign-extend.
REQ-012 SHALL have port: in_addr_low  input  2  load address bits [1:0].
REQ-013 SHALL have port: mem_rvalid  input  1  load data valid this cycle.
REQ-014 SHALL have port: mem_rdata  input  XLEN  load data word, little-endian.
REQ-015 SHALL have port: gpr_we_  output  1  GPR write enable, active low.
REQ-016 SHALL have port: gpr_wr_addr  output  5  GPR write address.
REQ-017 SHALL have port: gpr_wr_data  output  XLEN  GPR write data.
REQ-018 SHALL have port: rd_addr_0, rd_addr_1  input  5 each  decode read addresses.
REQ-019 SHALL have port: gpr_rd_data_0, gpr_rd_data_1  input  XLEN each  GPR read data.
REQ-020 SHALL have port: op_data_0, op_data_1  output  XLEN each  forwarded operands.
REQ-021 SHALL have port: load_busy  output  1  load pending in WAIT_MEM.
REQ-022 SHALL have port: load_busy_rd  output  5  destination of the pending load.

Function
REQ-023 SHALL implement FSM with states IDLE, WAIT_MEM, WRITE.
REQ-024 SHALL drive in_ready=1 in IDLE and WRITE, and in_ready=0 in WAIT_MEM.
REQ-025 SHALL capture rd_addr, rd_en, result and load fields on accept (in_valid & in_ready).
REQ-026 SHALL transition on accept: non-load -> WRITE; load -> WAIT_MEM. In WRITE with no accept -> IDLE.
REQ-027 SHALL, in WAIT_MEM, ignore in_valid, stay until mem_rvalid, then latch the formatted load data and go to WRITE.
REQ-028 SHALL ignore mem_rvalid outside WAIT_MEM.
REQ-029 SHALL drive gpr_we_=0 only in WRITE when captured rd_en=1 and rd_addr!=0; otherwise gpr_we_=1.
REQ-030 SHALL give non-load latency: accept at edge N -> write strobe during cycle N+1; load: mem_rvalid at edge M -> write strobe during cycle M+1.
REQ-031 SHALL select the load byte by addr_low and the halfword by addr_low[1]; addr_low[0] is ignored for half, and addr_low is ignored for word.
REQ-032 SHALL extend byte/half per load_unsigned to XLEN.
REQ-033 SHALL drive op_data_k = gpr_wr_data when gpr_we_=0 and rd_addr_k==gpr_wr_addr, else gpr_rd_data_k; x0 is never forwarded.
REQ-034 SHALL drive load_busy=1 and load_busy_rd=captured rd_addr in WAIT_MEM when rd_en=1 and rd_addr!=0; else 0 and 0.
REQ-035 SHALL sustain back-to-back non-load accepts at one write per cycle.

Reset
REQ-036 SHALL, on reset=1 at a clock edge, enter IDLE and set gpr_we_=1, gpr_wr_addr=0, gpr_wr_data=0, load_busy=0, load_busy_rd=0.
REQ-037 SHALL have reset override accept and mem_rvalid in the same cycle; a pending load is discarded with no write.

Verification
REQ-038 SHALL verify: ALU accept rd=5, result=0x1234 -> next cycle gpr_we_=0, addr 5, data 0x00001234; then IDLE.
REQ-039 SHALL verify: load rd=7, byte signed, addr_low=3; mem_rdata=0x80FF0011 after 3 cycles -> in_ready=0 and load_busy=1/rd=7 while waiting; writes 0xFFFFFF80.
REQ-040 SHALL verify: half unsigned, addr_low=2, mem_rdata=0xBEEF1234 -> writes 0x0000BEEF.
REQ-041 SHALL verify: accept rd=0 result=0xFFFFFFFF -> gpr_we_ stays 1; rd_addr_0=0 -> op_data_0=gpr_rd_data_0.
REQ-042 SHALL verify: back-to-back ALU rd=3 then rd=4, rd_addr_1=3 during the rd=3 write -> op_data_1=rd=3 result; two consecutive write strobes.
REQ-043 SHALL verify: reset asserted in WAIT_MEM together with mem_rvalid -> no write, in_ready=1 next cycle, load_busy=0.
